cpu_bus_decoder: RTL and testbench

//   Front end of the 65C816 bus, directly upstream of the read-data mux. Generates PHI2

---
 rtl/cpu_bus_decoder_if.sv | 33 +++
 rtl/cpu_bus_decoder.sv | 140 ++++++++++++++
 tb/tb_cpu_bus_decoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_decoder_if.sv
// CPU-side bus bundle for the 65C816 front end: CPU pins in, PHI2/RDY,
// latched bank, registered R/W and the active-low chip selects out.
interface cpu_bus_decoder_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_rwb;
  logic        cpu_vda;
  logic        cpu_vpa;
  logic        phi2;
  logic        cpu_rdy;
  logic [7:0]  bank_addr;
  logic        read_write;
  logic        io_video_n;
  logic        io_irq_n;
  logic        io_spi_n;
  logic        io_mmu_n;
  logic        ram_cs_n;
  logic        vram_cs_n;

  // CPU / stimulus side
  modport master (
    output cpu_addr, cpu_data_in, cpu_rwb, cpu_vda, cpu_vpa,
    input  phi2, cpu_rdy, bank_addr, read_write,
           io_video_n, io_irq_n, io_spi_n, io_mmu_n, ram_cs_n, vram_cs_n
  );

  // Decoder side
  modport slave (
    input  cpu_addr, cpu_data_in, cpu_rwb, cpu_vda, cpu_vpa,
    output phi2, cpu_rdy, bank_addr, read_write,
           io_video_n, io_irq_n, io_spi_n, io_mmu_n, ram_cs_n, vram_cs_n
  );
endinterface

// File: rtl/cpu_bus_decoder.sv
// 65C816 bus front end: divides clk down to PHI2, latches the bank byte off
// D[7:0] at the PHI2 rising edge, decodes the 24-bit address into one-hot
// active-low selects and stretches VRAM cycles with RDY wait states.
module cpu_bus_decoder #(
  parameter int         PHI2_DIV  = 4,
  parameter logic [7:0] IO_PAGE   = 8'hDF,
  parameter logic [3:0] VRAM_HI   = 4'h8,
  parameter int         VRAM_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  cpu_bus_decoder_if.slave  bus
);

  localparam int               CNT_W     = $clog2(PHI2_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PHI2_DIV - 1);
  localparam logic [3:0]       WAIT_INIT = 4'(VRAM_WAIT);

  typedef enum logic [1:0] {PH_LOW, PH_HIGH, PH_WAIT} state_t;

  // All members active-low; at most one is ever 0.
  typedef struct packed {
    logic video;
    logic irq;
    logic spi;
    logic mmu;
    logic ram;
    logic vram;
  } sel_t;

  localparam sel_t SEL_NONE = '1;

  logic [CNT_W-1:0] phase_cnt;
  logic             tick;
  state_t           state;
  logic             phi2_r;
  logic             rdy_r;
  logic [7:0]       bank_r;
  logic             rw_r;
  logic [3:0]       wait_cnt;
  sel_t             sel_r;
  sel_t             dec;
  logic             is_io_page;

  // PHI2 toggles on the clk edge that ends each half-period.
  assign tick = (phase_cnt == CNT_MAX);

  // Half-period counter: 0..PHI2_DIV-1, wrapping on the toggle edge.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset_n)  phase_cnt <= '0;
    else if (tick) phase_cnt <= '0;
    else           phase_cnt <= phase_cnt + CNT_W'(1);
  end

  // Address decode of {bank byte on D, A[15:0]}: I/O page, then VRAM, then RAM.
  always_comb begin
    // NOTE: default every output first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    dec        = SEL_NONE;
    is_io_page = (bus.cpu_data_in == 8'h00) && (bus.cpu_addr[15:8] == IO_PAGE);
    if (bus.cpu_vda || bus.cpu_vpa) begin
      if (is_io_page) begin
        case (bus.cpu_addr[7:5])
          3'd0:    dec.video = 1'b0;
          3'd1:    dec.irq   = 1'b0;
          3'd2:    dec.spi   = 1'b0;
          3'd3:    dec.mmu   = 1'b0;
          default: dec       = SEL_NONE;
        endcase
      end else if (bus.cpu_data_in[7:4] == VRAM_HI) begin
        dec.vram = 1'b0;
      end else if (!bus.cpu_data_in[7]) begin
        dec.ram = 1'b0;
      end
    end
  end

  // Bus-cycle FSM; every output is registered and moves only on a PHI2 toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= PH_LOW;
      phi2_r   <= 1'b0;
      rdy_r    <= 1'b1;
      bank_r   <= 8'h00;
      rw_r     <= 1'b1;
      wait_cnt <= 4'd0;
      sel_r    <= SEL_NONE;
    end else if (tick) begin
      phi2_r <= ~phi2_r;
      case (state)
        PH_LOW: begin
          if (!phi2_r) begin
            bank_r <= bus.cpu_data_in;
            rw_r   <= bus.cpu_rwb;
            sel_r  <= dec;
            if (!dec.vram && (VRAM_WAIT != 0)) begin
              wait_cnt <= WAIT_INIT;
              rdy_r    <= 1'b0;
              state    <= PH_WAIT;
            end else begin
              state <= PH_HIGH;
            end
          end
        end
        PH_HIGH: begin
          if (phi2_r) begin
            sel_r <= SEL_NONE;
            rw_r  <= 1'b1;
            state <= PH_LOW;
          end
        end
        PH_WAIT: begin
          // Selects, bank and R/W hold; only rises count down the wait states.
          if (!phi2_r) begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) begin
              rdy_r <= 1'b1;
              state <= PH_HIGH;
            end
          end
        end
        default: state <= PH_LOW;
      endcase
    end
  end

  assign bus.phi2       = phi2_r;
  assign bus.cpu_rdy    = rdy_r;
  assign bus.bank_addr  = bank_r;
  assign bus.read_write = rw_r;
  assign bus.io_video_n = sel_r.video;
  assign bus.io_irq_n   = sel_r.irq;
  assign bus.io_spi_n   = sel_r.spi;
  assign bus.io_mmu_n   = sel_r.mmu;
  assign bus.ram_cs_n   = sel_r.ram;
  assign bus.vram_cs_n  = sel_r.vram;

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Self-checking bench for cpu_bus_decoder: directed cycles for each decode
// region and boundary, randomized cycles against an address-map model,
// and an asynchronous reset in the middle of a stretched VRAM cycle.
module tb_cpu_bus_decoder;

  localparam int PHI2_DIV  = 4;
  localparam int VRAM_WAIT = 2;
  localparam int TIMEOUT   = 4 * PHI2_DIV;

  logic clk;
  logic reset_n;
  int   tests;
  int   failed;

  cpu_bus_decoder_if bus ();

  cpu_bus_decoder #(
    .PHI2_DIV (PHI2_DIV),
    .IO_PAGE  (8'hDF),
    .VRAM_HI  (4'h8),
    .VRAM_WAIT(VRAM_WAIT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {video, irq, spi, mmu, ram, vram}, active low
  logic [5:0] sel_obs;
  assign sel_obs = {bus.io_video_n, bus.io_irq_n, bus.io_spi_n,
                    bus.io_mmu_n, bus.ram_cs_n, bus.vram_cs_n};

  localparam logic [5:0] NONE  = 6'b111111;
  localparam logic [5:0] VIDEO = 6'b011111;
  localparam logic [5:0] IRQ   = 6'b101111;
  localparam logic [5:0] SPI   = 6'b110111;
  localparam logic [5:0] MMU   = 6'b111011;
  localparam logic [5:0] RAM   = 6'b111101;
  localparam logic [5:0] VRAM  = 6'b111110;

  // Memory map of the system, expressed as address ranges.
  function automatic logic [5:0] model_sel(input logic [23:0] a, input logic valid);
    int bank;
    int off;
    bank = int'(a[23:16]);
    off  = int'(a[15:0]);
    if (!valid) return NONE;
    if (bank == 0 && off >= 'hDF00 && off <= 'hDFFF) begin
      if (off < 'hDF20) return VIDEO;
      if (off < 'hDF40) return IRQ;
      if (off < 'hDF60) return SPI;
      if (off < 'hDF80) return MMU;
      return NONE;
    end
    if (bank >= 'h80 && bank <= 'h8F) return VRAM;
    if (bank < 'h80) return RAM;
    return NONE;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (sampling on falling clk) until phi2 reaches level; report clocks
  // taken and whether selects/read_write stayed put until the toggle.
  task automatic wait_phase(input logic level, output int n, output logic stable);
    logic [5:0] s0;
    logic       rw0;
    s0     = sel_obs;
    rw0    = bus.read_write;
    n      = 0;
    stable = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (bus.phi2 !== level && (sel_obs !== s0 || bus.read_write !== rw0))
        stable = 1'b0;
    end while (bus.phi2 !== level && n < TIMEOUT);
  endtask

  // One CPU bus cycle, entered and left with phi2 low just after the fall.
  task automatic bus_cycle(input string name, input logic [23:0] a,
                           input logic rwb, input logic vda, input logic vpa);
    logic [5:0] exp;
    int         w;
    int         n;
    logic       st;
    exp = model_sel(a, vda | vpa);
    w   = (exp == VRAM) ? VRAM_WAIT : 0;
    bus.cpu_addr    = a[15:0];
    bus.cpu_data_in = a[23:16];
    bus.cpu_rwb     = rwb;
    bus.cpu_vda     = vda;
    bus.cpu_vpa     = vpa;

    wait_phase(1'b1, n, st);
    check({name, " rise_clks"}, n, PHI2_DIV);
    check({name, " low_stable"}, st, 1);
    check({name, " sel"}, sel_obs, exp);
    check({name, " bank"}, bus.bank_addr, a[23:16]);
    check({name, " rw"}, bus.read_write, rwb);
    check({name, " rdy"}, bus.cpu_rdy, (w == 0));
    bus.cpu_data_in = 8'($urandom);

    for (int k = 0; k < w; k++) begin
      wait_phase(1'b0, n, st);
      check({name, " wfall_clks"}, n, PHI2_DIV);
      check({name, " wfall_sel"}, sel_obs, exp);
      check({name, " wfall_rdy"}, bus.cpu_rdy, 0);
      check({name, " wfall_rw"}, bus.read_write, rwb);
      bus.cpu_data_in = 8'($urandom);
      wait_phase(1'b1, n, st);
      check({name, " wrise_clks"}, n, PHI2_DIV);
      check({name, " wrise_sel"}, sel_obs, exp);
      check({name, " wrise_bank"}, bus.bank_addr, a[23:16]);
      check({name, " wrise_rdy"}, bus.cpu_rdy, (k == w - 1));
    end

    wait_phase(1'b0, n, st);
    check({name, " fall_clks"}, n, PHI2_DIV);
    check({name, " high_stable"}, st, 1);
    check({name, " fall_sel"}, sel_obs, NONE);
    check({name, " fall_rw"}, bus.read_write, 1);
    check({name, " fall_rdy"}, bus.cpu_rdy, 1);
    check({name, " fall_bank"}, bus.bank_addr, a[23:16]);
  endtask

  initial begin
    int          n;
    logic        st;
    logic [23:0] a;
    tests   = 0;
    failed  = 0;
    reset_n = 1'b0;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_data_in = 8'h00;
    bus.cpu_rwb     = 1'b1;
    bus.cpu_vda     = 1'b0;
    bus.cpu_vpa     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst phi2", bus.phi2, 0);
    check("rst rdy", bus.cpu_rdy, 1);
    check("rst bank", bus.bank_addr, 8'h00);
    check("rst rw", bus.read_write, 1);
    check("rst sel", sel_obs, NONE);
    reset_n = 1'b1;

    // Directed cycles
    bus_cycle("t1_video_rd", 24'h00DF05, 1'b1, 1'b1, 1'b0);
    bus_cycle("t2_bank1_wr", 24'h01DF40, 1'b0, 1'b1, 1'b0);
    bus_cycle("t3_vram_rd", 24'h821234, 1'b1, 1'b1, 1'b0);
    bus_cycle("t4_invalid0", 24'h000000, 1'b1, 1'b0, 1'b0);
    bus_cycle("t4_invalidC0", 24'hC00000, 1'b1, 1'b0, 1'b0);
    bus_cycle("t5_df00", 24'h00DF00, 1'b1, 1'b1, 1'b0);
    bus_cycle("t5_df20", 24'h00DF20, 1'b1, 1'b1, 1'b0);
    bus_cycle("t5_df40", 24'h00DF40, 1'b0, 1'b1, 1'b0);
    bus_cycle("t5_df60", 24'h00DF60, 1'b1, 1'b0, 1'b1);
    bus_cycle("t5_df80", 24'h00DF80, 1'b1, 1'b1, 1'b0);
    bus_cycle("b_dfff", 24'h00DFFF, 1'b1, 1'b1, 1'b0);
    bus_cycle("b_deff", 24'h00DEFF, 1'b1, 1'b1, 1'b0);
    bus_cycle("b_e000", 24'h00E000, 1'b0, 1'b1, 1'b0);
    bus_cycle("b_7fffff", 24'h7FFFFF, 1'b1, 1'b0, 1'b1);
    bus_cycle("b_800000", 24'h800000, 1'b0, 1'b1, 1'b1);
    bus_cycle("b_8fffff", 24'h8FFFFF, 1'b1, 1'b1, 1'b0);
    bus_cycle("b_900000", 24'h900000, 1'b1, 1'b1, 1'b0);

    // Randomized cycles across the address map
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       a = {8'h00, 8'hDF, 8'($urandom)};
        1:       a = {4'h8, 4'($urandom), 16'($urandom)};
        2:       a = {1'b0, 7'($urandom), 16'($urandom)};
        3:       a = 24'($urandom);
        default: a = {8'h00, 16'($urandom)};
      endcase
      bus_cycle("rand", a, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // T6: asynchronous reset while held in a VRAM wait state (phi2 high)
    bus.cpu_addr    = 16'h4321;
    bus.cpu_data_in = 8'h85;
    bus.cpu_rwb     = 1'b1;
    bus.cpu_vda     = 1'b1;
    bus.cpu_vpa     = 1'b0;
    wait_phase(1'b1, n, st);
    check("t6 pre_sel", sel_obs, VRAM);
    check("t6 pre_rdy", bus.cpu_rdy, 0);
    wait_phase(1'b0, n, st);
    wait_phase(1'b1, n, st);
    check("t6 held_rdy", bus.cpu_rdy, 0);
    check("t6 held_phi2", bus.phi2, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 rst_phi2", bus.phi2, 0);
    check("t6 rst_rdy", bus.cpu_rdy, 1);
    check("t6 rst_sel", sel_obs, NONE);
    check("t6 rst_bank", bus.bank_addr, 8'h00);
    check("t6 rst_rw", bus.read_write, 1);
    bus.cpu_vda     = 1'b0;
    bus.cpu_data_in = 8'h12;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_phase(1'b1, n, st);
    check("t6 first_rise_clks", n, PHI2_DIV);
    check("t6 post_bank", bus.bank_addr, 8'h12);
    check("t6 post_sel", sel_obs, NONE);
    check("t6 post_rdy", bus.cpu_rdy, 1);
    wait_phase(1'b0, n, st);
    check("t6 post_fall_clks", n, PHI2_DIV);
    bus_cycle("t6_after_mmu", 24'h00DF7F, 1'b0, 1'b1, 1'b0);
    bus_cycle("t6_after_vram", 24'h8A0000, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
